// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one multi-cycle data-memory port between the CPU
// load/store path (port 0) and the debug/DMA loader (port 1).
// Each access is latched on grant, presented to memory for LAT cycles,
// then acknowledged with a one-cycle ack pulse on the owning port.
// Build option: define DMEM_ARB_CPU_PRIO_EN for fixed priority to port 0
// on contention; otherwise ties are broken round-robin.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              stall0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              stall1,
    output logic [DATA_W-1:0] rdata,
    output logic              gnt,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Countdown start so that BUSY lasts exactly LAT cycles
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt_q, gnt_d;
`ifndef DMEM_ARB_CPU_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif

    logic any_req;
    logic winner;

    // Pick the winning port from the current requests
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant_q;
`endif
        end else begin
            winner = req1;
        end
    end

    // Next-state logic: grant and latch in IDLE, count down in BUSY, ack in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt_d   = gnt_q;
`ifndef DMEM_ARB_CPU_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_BUSY;
                    gnt_d   = winner;
                    cnt_d   = CNT_INIT;
                    we_d    = winner ? we1    : we0;
                    addr_d  = winner ? addr1  : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
`ifndef DMEM_ARB_CPU_PRIO_EN
                    last_grant_d = winner;
`endif
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight access without an ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt_q   <= 1'b0;
`ifndef DMEM_ARB_CPU_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
`ifndef DMEM_ARB_CPU_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Outputs decoded from the registered state and latched request
    always_comb begin
        busy      = (state_q == ST_BUSY) || (state_q == ST_RESP);
        ack0      = (state_q == ST_RESP) && !gnt_q;
        ack1      = (state_q == ST_RESP) && gnt_q;
        stall0    = req0 & ~ack0;
        stall1    = req1 & ~ack1;
        mem_we    = (state_q == ST_BUSY) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata     = rdata_q;
        gnt       = gnt_q;
    end

endmodule
